// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line, frame configuration and received byte / status strobes.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
);
  logic                      rx_in;
  logic                      par_en;
  logic                      par_typ;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled 2-of-3 majority bit recovery, start/data/parity/stop
// deframing, registered byte output with one-cycle valid and error strobes.
module uart_rx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  uart_rx_if.slave  bus
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned PW   = PRESCALE_WIDTH;
  localparam int unsigned BitW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   edge_q, edge_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [1:0]      smp_q, smp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            par_en_q, par_en_d;
  logic            par_typ_q, par_typ_d;
  logic            par_bad_q, par_bad_d;
  logic [DW-1:0]   p_data_q, p_data_d;
  logic            dv_q, dv_d;
  logic            pe_q, pe_d;
  logic            se_q, se_d;

  logic [PW-1:0]   half;
  logic            at_s0, at_s1, at_vote, at_last;
  logic            vote, par_exp;

  // Third sample is taken live so the decision registers one cycle after it.
  always_comb begin
    half    = presc_q >> 1;
    at_s0   = (edge_q == half - PW'(1));
    at_s1   = (edge_q == half);
    at_vote = (edge_q == half + PW'(1));
    at_last = (edge_q == presc_q - PW'(1));
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & bus.rx_in) | (smp_q[1] & bus.rx_in);
    par_exp = par_typ_q ? ~^shift_q : ^shift_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    smp_d     = smp_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != IDLE) begin
      edge_d = at_last ? '0 : edge_q + PW'(1);
      if (at_s0) smp_d[0] = bus.rx_in;
      if (at_s1) smp_d[1] = bus.rx_in;
    end

    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!bus.rx_in) begin
          state_d   = START;
          edge_d    = PW'(1);
          presc_d   = bus.prescale;
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (at_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[DW-1:1]};
        if (at_last) begin
          bit_d = bit_q + BitW'(1);
          if (bit_q == BitW'(DW - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_vote) par_bad_d = (vote != par_exp);
        if (at_last) state_d = STOP;
      end
      STOP: begin
        // Return to IDLE mid stop bit so an early following start edge is caught.
        if (at_vote) begin
          state_d = IDLE;
          edge_d  = '0;
          se_d    = ~vote;
          pe_d    = par_en_q & par_bad_q;
          if (vote && !(par_en_q && par_bad_q)) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, stop error, glitch rejection, reset.
module tb_uart_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) u_if ();

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  int dv_n = 0, pe_n = 0, se_n = 0;
  int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
  always @(negedge clk) begin
    if (u_if.data_valid) begin dv_n++; dv_cyc = cyc; end
    if (u_if.par_err)    begin pe_n++; pe_cyc = cyc; end
    if (u_if.stp_err)    begin se_n++; se_cyc = cyc; end
  end

  int n_chk = 0;
  int n_bad = 0;
  int t0 = 0;
  int dv_b = 0, pe_b = 0, se_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    dv_b = dv_n;
    pe_b = pe_n;
    se_b = se_n;
  endtask

  task automatic chk_cnt(input string tag, input int edv, input int epe, input int ese);
    chk({tag, "_dv_cnt"}, 32'(dv_n - dv_b), 32'(edv));
    chk({tag, "_pe_cnt"}, 32'(pe_n - pe_b), 32'(epe));
    chk({tag, "_se_cnt"}, 32'(se_n - se_b), 32'(ese));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame a cycle at a time; call just after a rising edge.
  task automatic send(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                      input bit pbit, input bit stp, input int spike, input int max_cyc);
    logic [10:0] bits;
    int nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = stp;
      nb       = 11;
    end else begin
      bits[9]  = stp;
      nb       = 10;
    end
    u_if.prescale = PW'(p);
    u_if.par_en   = pen;
    u_if.par_typ  = ptyp;
    t0 = cyc;
    for (int c = 0; c < nb * p && c < max_cyc; c++) begin
      u_if.rx_in = (c == spike) ? 1'b0 : bits[c / p];
      @(posedge clk); #1;
    end
    u_if.rx_in = 1'b1;
  endtask

  initial begin
    u_if.rx_in    = 1'b1;
    u_if.par_en   = 1'b0;
    u_if.par_typ  = 1'b0;
    u_if.prescale = PW'(8);
    rst_n = 1'b0;
    idle(3);
    chk("rst_pdata", 32'(u_if.p_data), 32'h0);
    chk("rst_dv",    32'(u_if.data_valid), 32'h0);
    chk("rst_pe",    32'(u_if.par_err), 32'h0);
    chk("rst_se",    32'(u_if.stp_err), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // P=8, no parity, 0xED
    snap();
    send(8'hED, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 100000);
    idle(8);
    chk_cnt("t1", 1, 0, 0);
    chk("t1_lat",  32'(dv_cyc - t0), 32'd78);
    chk("t1_data", 32'(u_if.p_data), 32'hED);

    // P=8, even parity, correct parity bit 0
    snap();
    send(8'hED, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 100000);
    idle(8);
    chk_cnt("t2a", 1, 0, 0);
    chk("t2a_lat",  32'(dv_cyc - t0), 32'd86);
    chk("t2a_data", 32'(u_if.p_data), 32'hED);

    // Same frame, wrong parity bit
    snap();
    send(8'hED, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 100000);
    idle(8);
    chk_cnt("t2b", 0, 1, 0);
    chk("t2b_lat",  32'(pe_cyc - t0), 32'd86);
    chk("t2b_data", 32'(u_if.p_data), 32'hED);

    // P=16, stop bit 0
    snap();
    send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 100000);
    idle(40);
    chk_cnt("t3", 0, 0, 1);
    chk("t3_lat",  32'(se_cyc - t0), 32'd154);
    chk("t3_data", 32'(u_if.p_data), 32'hED);

    // P=16, two-cycle low glitch on idle line
    snap();
    u_if.prescale = PW'(16);
    u_if.rx_in    = 1'b0;
    idle(2);
    u_if.rx_in    = 1'b1;
    idle(40);
    chk_cnt("t4a", 0, 0, 0);

    // P=16, one-cycle low spike at edge 8 of data bit 0 (a '1')
    snap();
    send(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 16 + 8, 100000);
    idle(16);
    chk_cnt("t4b", 1, 0, 0);
    chk("t4b_data", 32'(u_if.p_data), 32'hC3);

    // P=32, odd parity, back-to-back 0x55 then 0xA3 (both parity bits 1)
    snap();
    send(8'h55, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1, 100000);
    chk_cnt("t5a", 1, 0, 0);
    chk("t5a_lat",  32'(dv_cyc - t0), 32'd338);
    chk("t5a_data", 32'(u_if.p_data), 32'h55);
    send(8'hA3, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1, 100000);
    idle(8);
    chk_cnt("t5b", 2, 0, 0);
    chk("t5b_lat",  32'(dv_cyc - t0), 32'd338);
    chk("t5b_data", 32'(u_if.p_data), 32'hA3);

    // Reset in the middle of the data bits of 0x3C
    snap();
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pdata", 32'(u_if.p_data), 32'h0);
    chk("t6_rst_dv",    32'(u_if.data_valid), 32'h0);
    chk("t6_rst_pe",    32'(u_if.par_err), 32'h0);
    chk("t6_rst_se",    32'(u_if.stp_err), 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    chk_cnt("t6_abort", 0, 0, 0);
    snap();
    send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 100000);
    idle(8);
    chk_cnt("t6", 1, 0, 0);
    chk("t6_lat",  32'(dv_cyc - t0), 32'd78);
    chk("t6_data", 32'(u_if.p_data), 32'h81);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
